// File: rtl/dac_top_level.sv
`default_nettype none
`timescale 1ns/1ps
// dac_top_level: behavioural model of a segmented current-steering DAC (binary LSB + thermometer MSB).
// Optional macro DAC_ATB_EN enables the 10-channel analog test bus; otherwise atb is held at 0.0.
module dac_top_level #(
   parameter real RLOAD    = 150.0,
   parameter real ILSB_NOM = 1.0e-6,
   parameter int  NBIN     = 7,
   parameter int  NTHERM   = 17
) (
   input  logic              clkin,
   input  logic              pdb,
   input  logic              clkinb,
   input  logic [0:NBIN-1]   datainbin,
   input  logic [0:NBIN-1]   datainbinb,
   input  logic [0:NTHERM-1] dataintherm,
   input  logic [0:NTHERM-1] datainthermb,
   input  real               dataical,
   input  real               vddana_1p8,
   input  real               vddana_0p8,
   input  real               vssana,
   input  logic [0:9]        atb_ena,
   output real               Vout,
   output real               Voutb,
   output real               Ical,
   output real               atb [0:9]
);

   localparam int c_code_w     = 12;
   localparam int c_full_scale = (NTHERM << NBIN) + (1 << NBIN) - 1;

   logic [c_code_w-1:0] w_code_d;
   logic [c_code_w-1:0] w_ncode_d;
   logic [c_code_w-1:0] r_code;
   logic [c_code_w-1:0] r_ncode;

   real  w_dcal;
   real  w_ilsb;
   logic w_supok;
   logic w_on;
   logic w_unused;

   // Invalid pairs (data == complement) contribute to neither sum; unit positions do not matter.
   always_comb begin
      w_code_d  = '0;
      w_ncode_d = '0;
      for (int i = 0; i < NTHERM; i++) begin
         if (dataintherm[i] != datainthermb[i]) begin
            if (dataintherm[i])
               w_code_d = w_code_d + (c_code_w'(1) << NBIN);
            else
               w_ncode_d = w_ncode_d + (c_code_w'(1) << NBIN);
         end
      end
      for (int i = 0; i < NBIN; i++) begin
         if (datainbin[i] != datainbinb[i]) begin
            if (datainbin[i])
               w_code_d = w_code_d + (c_code_w'(1) << (NBIN - 1 - i));
            else
               w_ncode_d = w_ncode_d + (c_code_w'(1) << (NBIN - 1 - i));
         end
      end
   end

   always_ff @(posedge clkin or negedge pdb) begin
      if (!pdb) begin
         r_code  <= '0;
         r_ncode <= '0;
      end else begin
         r_code  <= w_code_d;
         r_ncode <= w_ncode_d;
      end
   end

   // Analog section is evaluated continuously so supply/trim changes act without a clock edge.
   always_comb begin
      if (dataical > 0.5)
         w_dcal = 0.5;
      else if (dataical < -0.5)
         w_dcal = -0.5;
      else
         w_dcal = dataical;
      w_ilsb  = ILSB_NOM * (1.0 + w_dcal);
      w_supok = (vddana_1p8 >= 1.62) && (vddana_0p8 >= 0.72);
      w_on    = pdb && w_supok;
      if (w_on) begin
         Vout  = vssana + RLOAD * real'(r_code) * w_ilsb;
         Voutb = vssana + RLOAD * real'(r_ncode) * w_ilsb;
         Ical  = real'(c_full_scale) * w_ilsb;
      end else begin
         Vout  = vssana;
         Voutb = vssana;
         Ical  = 0.0;
      end
   end

`ifdef DAC_ATB_EN
   always_comb begin
      for (int i = 0; i < 10; i++)
         atb[i] = 0.0;
      if (pdb) begin
         if (atb_ena[0]) atb[0] = vddana_1p8;
         if (atb_ena[1]) atb[1] = vddana_0p8;
         if (atb_ena[2]) atb[2] = vssana;
         if (atb_ena[3]) atb[3] = Vout;
         if (atb_ena[4]) atb[4] = Voutb;
         if (atb_ena[5]) atb[5] = RLOAD * Ical;
         if (atb_ena[6]) atb[6] = vddana_0p8 * real'(r_code) / real'(c_full_scale);
         for (int i = 7; i < 10; i++)
            if (atb_ena[i]) atb[i] = vssana;
      end
   end

   assign w_unused = clkinb;
`else
   always_comb begin
      for (int i = 0; i < 10; i++)
         atb[i] = 0.0;
   end

   assign w_unused = clkinb ^ (^atb_ena);
`endif

endmodule
`default_nettype wire

// File: tb/tb_dac_top_level.sv
`default_nettype none
`timescale 1ns/1ps
// tb_dac_top_level: directed self-checking bench for dac_top_level.
module tb_dac_top_level;

   logic        clkin = 1'b0;
   logic        pdb;
   logic        clkinb;
   logic [0:6]  datainbin;
   logic [0:6]  datainbinb;
   logic [0:16] dataintherm;
   logic [0:16] datainthermb;
   real         dataical;
   real         vddana_1p8;
   real         vddana_0p8;
   real         vssana;
   logic [0:9]  atb_ena;
   real         Vout;
   real         Voutb;
   real         Ical;
   real         atb [0:9];

   int n_chk  = 0;
   int n_fail = 0;

   dac_top_level u_dut (
      .clkin        (clkin),
      .pdb          (pdb),
      .clkinb       (clkinb),
      .datainbin    (datainbin),
      .datainbinb   (datainbinb),
      .dataintherm  (dataintherm),
      .datainthermb (datainthermb),
      .dataical     (dataical),
      .vddana_1p8   (vddana_1p8),
      .vddana_0p8   (vddana_0p8),
      .vssana       (vssana),
      .atb_ena      (atb_ena),
      .Vout         (Vout),
      .Voutb        (Voutb),
      .Ical         (Ical),
      .atb          (atb)
   );

   always #5 clkin = ~clkin;
   assign clkinb = ~clkin;

   task automatic check(input string tag, input real got, input real exp);
      real d;
      n_chk++;
      d = got - exp;
      if (d < 0.0) d = -d;
      if (d > 1.0e-9) begin
         n_fail++;
         $display("FAIL %s: got %0.9g expected %0.9g", tag, got, exp);
      end
   endtask

   // First t thermometer units on, binary word b (MSB = weight 64); all pairs valid.
   task automatic set_data(input int t, input logic [6:0] b);
      for (int i = 0; i < 17; i++) begin
         dataintherm[i]  = (i < t);
         datainthermb[i] = !(i < t);
      end
      datainbin  = b;
      datainbinb = ~b;
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clkin);
      #1;
   endtask

   initial begin
      pdb        = 1'b0;
      dataical   = 0.0;
      vddana_1p8 = 1.8;
      vddana_0p8 = 0.8;
      vssana     = 0.0;
      atb_ena    = '0;
      set_data(0, 7'd0);
      tick();
      check("rst_vout",  Vout,  0.0);
      check("rst_voutb", Voutb, 0.0);
      check("rst_ical",  Ical,  0.0);

      pdb = 1'b1;
      tick();
      check("zero_vout",  Vout,  0.0);
      check("zero_voutb", Voutb, 0.34545);
      check("zero_ical",  Ical,  2.303e-3);

      set_data(17, 7'd127);
      tick();
      check("fs_vout",  Vout,  0.34545);
      check("fs_voutb", Voutb, 0.0);

      set_data(9, 7'd0);
      tick();
      check("mid_vout",  Vout,  0.1728);
      check("mid_voutb", Voutb, 0.17265);

      // code 85, complement 2*128... : 16*128 + 42 = 2090? no: 17*128 + 42 = 2218
      set_data(0, 7'd85);
      tick();
      check("bin_vout",  Vout,  0.01275);
      check("bin_voutb", Voutb, 0.3327);

      set_data(0, 7'd0);
      #2;
      check("hold_vout",  Vout,  0.01275);
      check("hold_voutb", Voutb, 0.3327);
      tick();
      check("load_vout", Vout, 0.0);

      set_data(17, 7'd127);
      tick();
      pdb = 1'b0;
      #1;
      check("pd_vout",  Vout,  0.0);
      check("pd_voutb", Voutb, 0.0);
      check("pd_ical",  Ical,  0.0);
      tick();
      tick();
      check("pd_edge_vout", Vout, 0.0);
      pdb = 1'b1;
      #1;
      check("pu_noedge_voutb", Voutb, 0.0);
      check("pu_noedge_ical",  Ical,  2.303e-3);
      tick();
      check("pu_vout", Vout, 0.34545);

      dataical = 0.1;
      #1;
      check("trim_vout", Vout, 0.379995);
      check("trim_ical", Ical, 2.5333e-3);
      dataical = 0.8;
      #1;
      check("clamp_ical", Ical, 3.4545e-3);
      dataical = 0.0;

      // Unit 0 invalid (data = complement = 1); the other 16 units off -> 2048 + 127
      set_data(0, 7'd0);
      dataintherm[0]  = 1'b1;
      datainthermb[0] = 1'b1;
      tick();
      check("inv_vout",  Vout,  0.0);
      check("inv_voutb", Voutb, 0.32625);

      vddana_0p8 = 0.7;
      #1;
      check("sup_voutb", Voutb, 0.0);
      check("sup_ical",  Ical,  0.0);
      vddana_0p8 = 0.8;
      #1;
      check("sup_ok_voutb", Voutb, 0.32625);

      atb_ena = 10'b1000000000;
      #1;
`ifdef DAC_ATB_EN
      check("atb0", atb[0], 1.8);
`else
      check("atb0", atb[0], 0.0);
`endif
      check("atb1", atb[1], 0.0);
      check("atb4", atb[4], 0.0);

      set_data(17, 7'd127);
      atb_ena = '1;
      tick();
`ifdef DAC_ATB_EN
      check("atb3", atb[3], 0.34545);
      check("atb6", atb[6], 0.8);
`else
      check("atb3", atb[3], 0.0);
      check("atb6", atb[6], 0.0);
`endif
      pdb = 1'b0;
      #1;
      check("atb0_pd", atb[0], 0.0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
